fifo_burst_reader: RTL and testbench

Read-side controller for the 16-bit asynchronous sample FIFO. It sits in the read clock domain and monitors the FIFO water level. When a full burst is available, or when a flush is requested, it drains the FIFO and emits a framed burst on a valid/ready stream toward the host link. Each frame is: sync word, length word, N data words, XOR checksum word.

---
 rtl/fifo_rd_pkg.sv | 28 ++
 rtl/fifo_rd_skid.sv | 64 ++++++
 rtl/fifo_burst_reader.sv | 217 +++++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
//   Shared definitions for the sample-FIFO burst reader.
//   - DATA_W_DEF / LVL_W_DEF : default stream and water-level widths
//   - SYNC_WORD              : first word of every frame
//   - rd_state_t             : framing FSM states
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LVL_W_DEF  = 12;

    localparam logic [15:0] SYNC_WORD = 16'hA55A;

    // IDLE     : watching the water level / pending flush
    // HDR_SYNC : presenting the sync word (m_sof)
    // HDR_LEN  : presenting the frame length word
    // DATA     : draining len words from the FIFO through the skid buffer
    // TAIL     : presenting the XOR checksum (m_last)
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_SYNC = 3'd1,
        HDR_LEN  = 3'd2,
        DATA     = 3'd3,
        TAIL     = 3'd4
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
//   Two-entry skid buffer sitting behind the FIFO read port. The FIFO
//   delivers data one cycle after its read enable, so a read issued in
//   cycle t is marked pending and pushed in cycle t+1.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rd_issue     : FIFO read enable issued this cycle
//   rd_data      : FIFO read data (valid the cycle after rd_issue)
//   pop          : head word accepted downstream this cycle
//   head         : current head word
//   count        : entries currently held (0..2)
//   pend         : a read issued last cycle whose data arrives this cycle
// ---------------------------------------------------------------------------
module fifo_rd_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_issue,
    input  logic [W-1:0] rd_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         pend
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;

    // Pointer/occupancy state is reset; a reset drops any read still in
    // flight because pend clears, so late FIFO data is never pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            pend <= rd_issue;
            if (pend) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, pend} - {1'b0, pop};
        end
    end

    // Storage carries no reset; entries are only read when count says so.
    always_ff @(posedge clk) begin
        if (pend) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Read-side controller of the sample FIFO. Waits for a full burst (or a
//   flush request), then drains the FIFO into a framed valid/ready stream:
//     SYNC_WORD (m_sof), length, len data words, XOR checksum (m_last).
//
// Stream handshake: a word transfers on a cycle where m_valid && m_ready.
// Once m_valid is raised, m_valid/m_data/m_sof/m_last hold until that
// transfer happens; all four are decoded from registered state only, so
// m_ready never reaches them combinationally.
//
// Ports:
//   clk, rst_n     : read-domain clock, asynchronous active-low reset
//   cfg_burst_len  : words per normal burst (0 behaves as 1)
//   flush_req      : one-cycle pulse, frame whatever the FIFO holds
//   fifo_rd_en     : FIFO read enable
//   fifo_rd_data   : FIFO data, valid one cycle after fifo_rd_en
//   fifo_rd_empty  : FIFO empty flag
//   fifo_rd_level  : FIFO read water level
//   m_valid/m_data/m_sof/m_last/m_ready : output stream
//   busy           : frame in progress (left IDLE, checksum not yet taken)
//   frame_cnt      : completed frames, wrapping
// ---------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                LVL_W     = LVL_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_WORD = fifo_rd_pkg::SYNC_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LVL_W-1:0]  cfg_burst_len,
    input  logic              flush_req,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    rd_state_t         state_q;
    rd_state_t         state_d;

    logic [LVL_W-1:0]  len_q;        // frame length, frozen at frame start
    logic [LVL_W-1:0]  req_cnt_q;    // FIFO reads issued this frame
    logic [LVL_W-1:0]  sent_cnt_q;   // data words accepted this frame
    logic [DATA_W-1:0] csum_q;
    logic              flush_pend_q;

    logic [LVL_W-1:0]  eff_len;
    logic              start_burst;
    logic              start_flush;
    logic              flush_drop;
    logic              frame_start;

    logic              xfer;
    logic              skid_pop;
    logic [1:0]        occ_after;
    logic [2:0]        credit;
    logic              last_data;

    logic [DATA_W-1:0] skid_head;
    logic [1:0]        skid_cnt;
    logic              skid_pend;

    // ------------------------------------------------------------------
    // Frame start decisions (IDLE only). A level hit takes priority over
    // a pending flush; an empty-FIFO flush just retires the request.
    // ------------------------------------------------------------------
    assign eff_len     = (cfg_burst_len == '0) ? LVL_W'(1) : cfg_burst_len;
    assign start_burst = (state_q == IDLE) && (fifo_rd_level >= eff_len);
    assign start_flush = (state_q == IDLE) && !start_burst && flush_pend_q
                         && (fifo_rd_level != '0);
    assign flush_drop  = (state_q == IDLE) && !start_burst && flush_pend_q
                         && (fifo_rd_level == '0);
    assign frame_start = start_burst || start_flush;

    assign last_data   = (sent_cnt_q == (len_q - LVL_W'(1)));
    assign busy        = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Skid buffer between FIFO read port and the stream
    // ------------------------------------------------------------------
    fifo_rd_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_issue (fifo_rd_en),
        .rd_data  (fifo_rd_data),
        .pop      (skid_pop),
        .head     (skid_head),
        .count    (skid_cnt),
        .pend     (skid_pend)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs, read issue and next state
    // ------------------------------------------------------------------
    always_comb begin
        m_valid    = 1'b0;
        m_data     = '0;
        m_sof      = 1'b0;
        m_last     = 1'b0;
        xfer       = 1'b0;
        skid_pop   = 1'b0;
        occ_after  = 2'd0;
        credit     = 3'd0;
        fifo_rd_en = 1'b0;
        state_d    = state_q;

        case (state_q)
            HDR_SYNC: begin
                m_valid = 1'b1;
                m_data  = SYNC_WORD;
                m_sof   = 1'b1;
            end
            HDR_LEN: begin
                m_valid = 1'b1;
                m_data  = DATA_W'(len_q);
            end
            DATA: begin
                m_valid = (skid_cnt != 2'd0);
                m_data  = skid_head;
            end
            TAIL: begin
                m_valid = 1'b1;
                m_data  = csum_q;
                m_last  = 1'b1;
            end
            default: begin
            end
        endcase

        xfer     = m_valid && m_ready;
        skid_pop = (state_q == DATA) && xfer;

        // Buffer credit counts the slot freed by this cycle's pop, so a
        // read can be issued every cycle while the stream keeps accepting.
        // Without that, a 2-entry buffer with a 1-cycle read latency would
        // bubble every third cycle.
        occ_after = skid_cnt - {1'b0, skid_pop};
        credit    = {1'b0, occ_after} + {2'b00, skid_pend};

        // Prefetch starts as soon as the frame header begins.
        if ((state_q == HDR_SYNC || state_q == HDR_LEN || state_q == DATA)
            && !fifo_rd_empty && (req_cnt_q < len_q) && (credit < 3'd2)) begin
            fifo_rd_en = 1'b1;
        end

        case (state_q)
            IDLE:     if (frame_start)            state_d = HDR_SYNC;
            HDR_SYNC: if (xfer)                   state_d = HDR_LEN;
            HDR_LEN:  if (xfer)                   state_d = DATA;
            DATA:     if (skid_pop && last_data)  state_d = TAIL;
            TAIL:     if (xfer)                   state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame datapath: length, counters, checksum, flush latch, frame count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            req_cnt_q    <= '0;
            sent_cnt_q   <= '0;
            csum_q       <= '0;
            flush_pend_q <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            // A new request wins over the clear in the same cycle, so a
            // flush arriving with a level hit survives to the next IDLE.
            flush_pend_q <= (flush_pend_q && !(frame_start || flush_drop))
                            || flush_req;

            if (frame_start) begin
                len_q      <= start_burst ? eff_len : fifo_rd_level;
                req_cnt_q  <= '0;
                sent_cnt_q <= '0;
                csum_q     <= '0;
            end else begin
                if (fifo_rd_en) begin
                    req_cnt_q <= req_cnt_q + LVL_W'(1);
                end
                if (skid_pop) begin
                    sent_cnt_q <= sent_cnt_q + LVL_W'(1);
                    csum_q     <= csum_q ^ skid_head;
                end
            end

            if (state_q == TAIL && xfer) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader. A small FIFO model feeds the DUT
//   (data one cycle after read enable); expected frames are queued in
//   exp_q and compared word by word as they transfer.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int LW = 12;
    localparam logic [DW-1:0] SYNC = 16'hA55A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] cfg_burst_len;
    logic          flush_req;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_level;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic [15:0]   frame_cnt;

    fifo_burst_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_burst_len (cfg_burst_len),
        .flush_req     (flush_req),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_level (fifo_rd_level),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_sof         (m_sof),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;
    logic [7:0]    fifo_cnt;
    logic          lvl_ovr = 1'b0;
    logic [LW-1:0] lvl_ovr_val = '0;
    logic          fifo_clear = 1'b0;
    logic          rd_en_s = 1'b0;

    assign fifo_cnt      = wr_ptr - rd_ptr;
    assign fifo_rd_empty = (fifo_cnt == 8'd0);
    assign fifo_rd_level = lvl_ovr ? lvl_ovr_val : LW'(fifo_cnt);

    // ---------------- scoreboard / bookkeeping ----------------
    logic [DW+1:0] exp_q[$];     // {last, sof, data}
    logic [DW-1:0] pay [32];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            gap_cnt = 0;
    int            rd_empty_viol = 0;
    int            max_occ = 0;
    int            frame_idx = 0;
    int            sof_cyc = 0;
    int            last_cyc = 0;
    int            ready_mode = 0;   // 0: ready held high, 1: toggle
    logic          prev_busy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW+2:0] prev_word = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Emulates the FIFO read port: the read enable seen at the negedge is
    // acted on at the following posedge, data registered for the DUT.
    task automatic fifo_model();
        forever begin
            @(posedge clk);
            if (fifo_clear) begin
                rd_ptr <= wr_ptr;
            end else if (rd_en_s) begin
                fifo_rd_data <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + 8'd1;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_ready = 1'b1;
            else                 m_ready = ~m_ready;
        end
    endtask

    task automatic monitor();
        logic [DW+1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            rd_en_s = fifo_rd_en;
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (fifo_rd_en && fifo_rd_empty) rd_empty_viol++;
                if (busy && !prev_busy) begin
                    rd_cnt  = 0;
                    gap_cnt = 0;
                end
                if (fifo_rd_en) rd_cnt++;
                if (busy && !m_valid) gap_cnt++;
                prev_busy = busy;
                if (int'(dut.u_skid.occ) > max_occ) max_occ = int'(dut.u_skid.occ);
                if (prev_stall)
                    check("hold_stable", {13'd0, m_valid, m_sof, m_last, m_data},
                          {13'd0, prev_word});
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_valid, m_sof, m_last, m_data};
                if (m_valid && m_ready) begin
                    check("extra_word", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("word", {14'd0, m_last, m_sof, m_data}, {14'd0, e});
                    end
                    if (m_sof) begin
                        frame_idx = 0;
                        sof_cyc   = cyc;
                    end else begin
                        frame_idx++;
                    end
                    if (m_last) last_cyc = cyc;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) mem[wr_ptr + 8'(i)] = pay[i];
        wr_ptr = wr_ptr + 8'(n);
    endtask

    task automatic expect_frame(input int n);
        logic [DW-1:0] x;
        x = '0;
        exp_q.push_back({2'b01, SYNC});
        exp_q.push_back({2'b00, DW'(n)});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b00, pay[i]});
            x = x ^ pay[i];
        end
        exp_q.push_back({2'b10, x});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, {31'd0, (exp_q.size() == 0) && !busy}, 32'd1);
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  {31'd0, fifo_rd_en}, 32'd0);
        check({tag, "_valid"},  {31'd0, m_valid},    32'd0);
        check({tag, "_data"},   {16'd0, m_data},     32'd0);
        check({tag, "_sof"},    {31'd0, m_sof},      32'd0);
        check({tag, "_last"},   {31'd0, m_last},     32'd0);
        check({tag, "_busy"},   {31'd0, busy},       32'd0);
        check({tag, "_fcnt"},   {16'd0, frame_cnt},  32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n         = 1'b0;
        cfg_burst_len = LW'(4);
        flush_req     = 1'b0;
        m_ready       = 1'b1;
        fifo_rd_data  = '0;
        fork
            fifo_model();
            ready_driver();
            monitor();
        join_none

        // Reset state, FIFO preloaded for test 1
        for (int i = 0; i < 4; i++) pay[i] = DW'(i + 1);
        load_words(4);
        tick(3);
        check_reset_outputs("reset");

        // 1: len 4, full throughput, checksum 1^2^3^4 = 4
        expect_frame(4);
        rst_n = 1'b1;
        wait_done("t1", 100);
        check("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("t1_rd_en_cycles", rd_cnt, 4);
        check("t1_span", last_cyc - sof_cyc, 6);

        // 2: flush with 3 words below an 8-word threshold, then empty flush
        cfg_burst_len = LW'(8);
        pay[0] = 16'h1234; pay[1] = 16'h00FF; pay[2] = 16'hF00F;
        load_words(3);
        tick(5);
        check("t2_idle_below_level", {31'd0, busy}, 32'd0);
        expect_frame(3);
        pulse_flush();
        wait_done("t2", 100);
        check("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        pulse_flush();
        tick(10);
        check("t2_empty_flush_busy", {31'd0, busy}, 32'd0);
        check("t2_flush_pend_clr", {31'd0, dut.flush_pend_q}, 32'd0);
        check("t2_empty_flush_fcnt", {16'd0, frame_cnt}, 32'd2);

        // 3: len 16 with m_ready toggling every cycle
        cfg_burst_len = LW'(16);
        for (int i = 0; i < 16; i++) pay[i] = 16'h0100 + DW'(i * 17);
        max_occ = 0;
        ready_mode = 1;
        expect_frame(16);
        load_words(16);
        wait_done("t3", 300);
        ready_mode = 0;
        tick(2);
        check("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        check("t3_max_occ_le2", {31'd0, max_occ <= 2}, 32'd1);

        // 4: len 8, only 5 words present, remaining 3 arrive later
        cfg_burst_len = LW'(8);
        for (int i = 0; i < 8; i++) pay[i] = 16'hC000 ^ DW'(i * 16'h0111);
        expect_frame(8);
        lvl_ovr_val = LW'(8);
        lvl_ovr     = 1'b1;
        load_words(5);
        tick(20);
        for (int i = 0; i < 3; i++) mem[wr_ptr + 8'(i)] = pay[5 + i];
        wr_ptr  = wr_ptr + 8'd3;
        lvl_ovr = 1'b0;
        wait_done("t4", 200);
        check("t4_frame_cnt", {16'd0, frame_cnt}, 32'd4);
        check("t4_stall_gap", {31'd0, gap_cnt >= 10}, 32'd1);
        check("t4_rd_en_cycles", rd_cnt, 8);
        check("rd_en_while_empty", rd_empty_viol, 0);

        // 5: async reset during the 3rd data word of a len-8 frame
        for (int i = 0; i < 8; i++) pay[i] = 16'h5A00 + DW'(i);
        expect_frame(8);
        load_words(8);
        n = 0;
        while (!(busy && frame_idx == 3) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reached_data3", {31'd0, busy && frame_idx == 3}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        fifo_clear = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        tick(3);
        fifo_clear = 1'b0;
        rst_n = 1'b1;
        tick(3);
        check("t5_idle_after_rst", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) pay[i] = 16'h7700 | DW'(i * 3);
        expect_frame(8);
        load_words(8);
        wait_done("t5", 100);
        check("t5_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // 6: cfg_burst_len 0 acts as 1; frame counter wrap
        cfg_burst_len = '0;
        pay[0] = 16'hBEEF;
        expect_frame(1);
        load_words(1);
        wait_done("t6a", 50);
        check("t6_len0_fcnt", {16'd0, frame_cnt}, 32'd2);
        tick(2);
        force dut.frame_cnt = 16'hFFFF;
        tick(1);
        release dut.frame_cnt;
        tick(1);
        check("t6_preset", {16'd0, frame_cnt}, 32'h0000FFFF);
        pay[0] = 16'h1357;
        expect_frame(1);
        load_words(1);
        wait_done("t6b", 50);
        check("t6_wrap", {16'd0, frame_cnt}, 32'd0);
        check("rd_en_while_empty_end", rd_empty_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
